axi_reg_slice: RTL and testbench

- Full AXI4 register slice, 64-bit data, 8-bit ID, for the PXIe board.
- Sits directly upstream of the DDR address mapper: the core/crossbar AXI master drives s_axi, and m_axi feeds the mapper's slave port.
- Breaks every valid/ready and payload combinational path on AW/W/AR.
- B/R are optionally registered, so the core-to-DDR path closes timing at core clock.
- Preserves ordering, IDs and burst attributes bit-exactly.

---
 rtl/axi_reg_slice_if.sv | 75 +++++++
 rtl/axi_reg_slice.sv | 176 +++++++++++++++++
 tb/tb_axi_reg_slice.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_reg_slice_if.sv
// AXI4 bundle (AW/W/B/AR/R) shared by both sides of axi_reg_slice.
// master drives requests and takes responses; slave is the mirror.
interface axi_reg_slice_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
);
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_reg_slice.sv
// Full AXI4 register slice: AW/W/AR always pass through a 2-entry skid buffer.
// Define AXI_REG_SLICE_RESP_EN to also register B and R; otherwise they are wires.
module axi_reg_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] up_data,
  input  logic         up_vld,
  output logic         up_rdy,
  output logic [W-1:0] dn_data,
  output logic         dn_vld,
  input  logic         dn_rdy
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t       state, state_nxt;
  logic         push, pop;
  logic         load_main, load_skid, skid_to_main;
  logic         rdy_q;
  logic         vld_p0;
  logic [W-1:0] main_p0;
  logic [W-1:0] skid_p1;

  assign push    = up_vld & rdy_q;
  assign pop     = vld_p0 & dn_rdy;
  assign up_rdy  = rdy_q;
  assign dn_vld  = vld_p0;
  assign dn_data = main_p0;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: load_main = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        // ready is low here, so a pop is the only possible event
        if (pop) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // handshake flops are decoded from the next state so both outputs come straight off a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_q  <= (state_nxt != FULL);
      vld_p0 <= (state_nxt != EMPTY);
    end
  end

  // p0 = main (drives downstream), p1 = skid (holds the beat caught during a stall)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main)         main_p0 <= up_data;
      else if (skid_to_main) main_p0 <= skid_p1;
      if (load_skid)         skid_p1 <= up_data;
    end
  end
endmodule

module axi_reg_slice #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_reg_slice_if.slave         s_axi,
  axi_reg_slice_if.master        m_axi
);
  localparam int AX_PW = ADDR_W + ID_W + 25;
  localparam int W_PW  = DATA_W + DATA_W/8 + 1;

  logic [AX_PW-1:0] aw_up, aw_dn, ar_up, ar_dn;
  logic [W_PW-1:0]  w_up, w_dn;

  assign aw_up = {s_axi.awaddr, s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                  s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos};
  assign {m_axi.awaddr, m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst,
          m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos} = aw_dn;

  axi_reg_slice_skid #(.W(AX_PW)) u_aw (
    .clk(clk), .rst(rst),
    .up_data(aw_up), .up_vld(s_axi.awvalid), .up_rdy(s_axi.awready),
    .dn_data(aw_dn), .dn_vld(m_axi.awvalid), .dn_rdy(m_axi.awready)
  );

  assign w_up = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_dn;

  axi_reg_slice_skid #(.W(W_PW)) u_w (
    .clk(clk), .rst(rst),
    .up_data(w_up), .up_vld(s_axi.wvalid), .up_rdy(s_axi.wready),
    .dn_data(w_dn), .dn_vld(m_axi.wvalid), .dn_rdy(m_axi.wready)
  );

  assign ar_up = {s_axi.araddr, s_axi.arid, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                  s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
  assign {m_axi.araddr, m_axi.arid, m_axi.arlen, m_axi.arsize, m_axi.arburst,
          m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos} = ar_dn;

  axi_reg_slice_skid #(.W(AX_PW)) u_ar (
    .clk(clk), .rst(rst),
    .up_data(ar_up), .up_vld(s_axi.arvalid), .up_rdy(s_axi.arready),
    .dn_data(ar_dn), .dn_vld(m_axi.arvalid), .dn_rdy(m_axi.arready)
  );

`ifdef AXI_REG_SLICE_RESP_EN
  localparam int B_PW = ID_W + 2;
  localparam int R_PW = DATA_W + ID_W + 3;

  logic [B_PW-1:0] b_up, b_dn;
  logic [R_PW-1:0] r_up, r_dn;

  // response channels flow m_axi -> s_axi, so the m side is upstream here
  assign b_up = {m_axi.bid, m_axi.bresp};
  assign {s_axi.bid, s_axi.bresp} = b_dn;

  axi_reg_slice_skid #(.W(B_PW)) u_b (
    .clk(clk), .rst(rst),
    .up_data(b_up), .up_vld(m_axi.bvalid), .up_rdy(m_axi.bready),
    .dn_data(b_dn), .dn_vld(s_axi.bvalid), .dn_rdy(s_axi.bready)
  );

  assign r_up = {m_axi.rdata, m_axi.rid, m_axi.rresp, m_axi.rlast};
  assign {s_axi.rdata, s_axi.rid, s_axi.rresp, s_axi.rlast} = r_dn;

  axi_reg_slice_skid #(.W(R_PW)) u_r (
    .clk(clk), .rst(rst),
    .up_data(r_up), .up_vld(m_axi.rvalid), .up_rdy(m_axi.rready),
    .dn_data(r_dn), .dn_vld(s_axi.rvalid), .dn_rdy(s_axi.rready)
  );
`else
  assign s_axi.bid    = m_axi.bid;
  assign s_axi.bresp  = m_axi.bresp;
  assign s_axi.bvalid = m_axi.bvalid;
  assign m_axi.bready = s_axi.bready;

  assign s_axi.rdata  = m_axi.rdata;
  assign s_axi.rid    = m_axi.rid;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rlast  = m_axi.rlast;
  assign s_axi.rvalid = m_axi.rvalid;
  assign m_axi.rready = s_axi.rready;
`endif
endmodule

// File: tb/tb_axi_reg_slice.sv
// Scoreboard bench for axi_reg_slice: drivers queue expected beats, a negedge monitor pops and compares.
module tb_axi_reg_slice;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 8;
  localparam int AW_PW  = ADDR_W + ID_W + 25;
  localparam int W_PW   = DATA_W + DATA_W/8 + 1;
  localparam int B_PW   = ID_W + 2;
  localparam int R_PW   = DATA_W + ID_W + 3;
  localparam int STRESS_N = 300;
`ifdef AXI_REG_SLICE_RESP_EN
  localparam int R_LAT = 1;
`else
  localparam int R_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_reg_slice_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_if ();
  axi_reg_slice_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

  axi_reg_slice #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .s_axi(s_if.slave), .m_axi(m_if.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] aw_q[$], w_q[$], ar_q[$], b_q[$], r_q[$];
  logic [127:0] m_aw_pk, m_w_pk, m_ar_pk, s_b_pk, s_r_pk;
  logic [127:0] prev_aw, prev_w, prev_ar, prev_b, prev_r;
  logic [127:0] r_aw, r_w, r_ar, r_b, r_r;
  bit pend_aw, pend_w, pend_ar, pend_b, pend_r;
  bit test_w, test_ar, test_aw, stress_done, r_done;
  int w_up, w_dn, w_low, ar_low, aw_low, aw_dn, aw_up_first, aw_dn_first, aw_dn_last;

  assign m_aw_pk = {{(128-AW_PW){1'b0}}, m_if.awaddr, m_if.awid, m_if.awlen, m_if.awsize,
                    m_if.awburst, m_if.awlock, m_if.awcache, m_if.awprot, m_if.awqos};
  assign m_ar_pk = {{(128-AW_PW){1'b0}}, m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize,
                    m_if.arburst, m_if.arlock, m_if.arcache, m_if.arprot, m_if.arqos};
  assign m_w_pk  = {{(128-W_PW){1'b0}}, m_if.wdata, m_if.wstrb, m_if.wlast};
  assign s_b_pk  = {{(128-B_PW){1'b0}}, s_if.bid, s_if.bresp};
  assign s_r_pk  = {{(128-R_PW){1'b0}}, s_if.rdata, s_if.rid, s_if.rresp, s_if.rlast};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // channel: 0=AW 1=W 2=AR 3=B 4=R; returns just after the accepting edge
  task automatic wait_acc(input int ch);
    int n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      n++;
      case (ch)
        0: rdy = s_if.awready;
        1: rdy = s_if.wready;
        2: rdy = s_if.arready;
        3: rdy = m_if.bready;
        default: rdy = m_if.rready;
      endcase
    end while (!rdy && n < 2000);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL ch%0d_timeout: ready=0 after %0d cycles, required ready=1", ch, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [AW_PW-1:0] v);
    {s_if.awaddr, s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst,
     s_if.awlock, s_if.awcache, s_if.awprot, s_if.awqos} = v;
    s_if.awvalid = 1'b1;
    aw_q.push_back({{(128-AW_PW){1'b0}}, v});
    wait_acc(0);
    s_if.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [W_PW-1:0] v);
    {s_if.wdata, s_if.wstrb, s_if.wlast} = v;
    s_if.wvalid = 1'b1;
    w_q.push_back({{(128-W_PW){1'b0}}, v});
    wait_acc(1);
    s_if.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW_PW-1:0] v);
    {s_if.araddr, s_if.arid, s_if.arlen, s_if.arsize, s_if.arburst,
     s_if.arlock, s_if.arcache, s_if.arprot, s_if.arqos} = v;
    s_if.arvalid = 1'b1;
    ar_q.push_back({{(128-AW_PW){1'b0}}, v});
    wait_acc(2);
    s_if.arvalid = 1'b0;
  endtask

  task automatic send_b(input logic [B_PW-1:0] v);
    {m_if.bid, m_if.bresp} = v;
    m_if.bvalid = 1'b1;
    b_q.push_back({{(128-B_PW){1'b0}}, v});
    wait_acc(3);
    m_if.bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [R_PW-1:0] v);
    {m_if.rdata, m_if.rid, m_if.rresp, m_if.rlast} = v;
    m_if.rvalid = 1'b1;
    r_q.push_back({{(128-R_PW){1'b0}}, v});
    wait_acc(4);
    m_if.rvalid = 1'b0;
  endtask

  // Monitor: scoreboard pops, stall stability, and per-test probes.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend_aw = 0; pend_w = 0; pend_ar = 0; pend_b = 0; pend_r = 0;
    end else begin
      if (test_w) begin
        if (!s_if.wready) begin
          w_low++;
          chk("w_full_depth", w_up - w_dn, 2);
        end
        if (s_if.wvalid && s_if.wready) w_up++;
        if (m_if.wvalid && m_if.wready) w_dn++;
      end
      if (test_ar && !s_if.arready) ar_low++;
      if (test_aw) begin
        if (!s_if.awready) aw_low++;
        if (s_if.awvalid && s_if.awready && aw_up_first < 0) aw_up_first = cyc;
        if (m_if.awvalid && m_if.awready) begin
          if (aw_dn_first < 0) aw_dn_first = cyc;
          aw_dn_last = cyc;
          aw_dn++;
        end
      end

      if (pend_aw) chk_v("aw_hold", {m_if.awvalid, m_aw_pk[126:0]}, {1'b1, prev_aw[126:0]});
      if (pend_w)  chk_v("w_hold",  {m_if.wvalid,  m_w_pk[126:0]},  {1'b1, prev_w[126:0]});
      if (pend_ar) chk_v("ar_hold", {m_if.arvalid, m_ar_pk[126:0]}, {1'b1, prev_ar[126:0]});
      if (pend_b)  chk_v("b_hold",  {s_if.bvalid,  s_b_pk[126:0]},  {1'b1, prev_b[126:0]});
      if (pend_r)  chk_v("r_hold",  {s_if.rvalid,  s_r_pk[126:0]},  {1'b1, prev_r[126:0]});
      pend_aw = m_if.awvalid && !m_if.awready; prev_aw = m_aw_pk;
      pend_w  = m_if.wvalid  && !m_if.wready;  prev_w  = m_w_pk;
      pend_ar = m_if.arvalid && !m_if.arready; prev_ar = m_ar_pk;
      pend_b  = s_if.bvalid  && !s_if.bready;  prev_b  = s_b_pk;
      pend_r  = s_if.rvalid  && !s_if.rready;  prev_r  = s_r_pk;

      if (m_if.awvalid && m_if.awready) begin
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_extra: beat %0h seen, none required", m_aw_pk);
        end else chk_v("aw_beat", m_aw_pk, aw_q.pop_front());
      end
      if (m_if.wvalid && m_if.wready) begin
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_extra: beat %0h seen, none required", m_w_pk);
        end else chk_v("w_beat", m_w_pk, w_q.pop_front());
      end
      if (m_if.arvalid && m_if.arready) begin
        if (ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_extra: beat %0h seen, none required", m_ar_pk);
        end else chk_v("ar_beat", m_ar_pk, ar_q.pop_front());
      end
      if (s_if.bvalid && s_if.bready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra: beat %0h seen, none required", s_b_pk);
        end else chk_v("b_beat", s_b_pk, b_q.pop_front());
      end
      if (s_if.rvalid && s_if.rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_extra: beat %0h seen, none required", s_r_pk);
        end else chk_v("r_beat", s_r_pk, r_q.pop_front());
      end
    end
  end

  initial begin
    s_if.awvalid = 0; s_if.wvalid = 0; s_if.arvalid = 0;
    s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
    s_if.awlock = 0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 0;
    s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
    s_if.arlock = 0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0;
    s_if.bready = 0; s_if.rready = 0;
    m_if.bvalid = 0; m_if.bid = '0; m_if.bresp = '0;
    m_if.rvalid = 0; m_if.rdata = '0; m_if.rid = '0; m_if.rresp = '0; m_if.rlast = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.arready = 0;
    test_w = 0; test_ar = 0; test_aw = 0; stress_done = 0; r_done = 0;
    w_up = 0; w_dn = 0; w_low = 0; ar_low = 0; aw_low = 0; aw_dn = 0;
    aw_up_first = -1; aw_dn_first = -1; aw_dn_last = -1;

    // reset state, then readiness at the first edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", int'({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}), 0);
    chk("rst_readies", int'({s_if.awready, s_if.wready, s_if.arready}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'({s_if.awready, s_if.wready, s_if.arready}), 7);
    chk("valids_after_rst", int'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 0);
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1; s_if.bready = 1; s_if.rready = 1;

    // single AR beat: visible exactly one cycle after the handshake
    test_ar = 1;
    fork
      send_ar({64'h0000_0000_8000_1000, 8'h5A, 8'd7, 3'd3, 2'b01, 1'b0, 4'h3, 3'h2, 4'h0});
      begin
        @(negedge clk); chk("ar_lat_before", int'(m_if.arvalid), 0);
        @(negedge clk); chk("ar_lat_one",    int'(m_if.arvalid), 1);
        @(negedge clk); chk("ar_lat_after",  int'(m_if.arvalid), 0);
      end
    join
    idle(2);
    test_ar = 0;
    chk("ar_ready_low", ar_low, 0);
    chk("ar_drain", ar_q.size(), 0);

    // 8-beat W burst, downstream stalled for three cycles
    test_w = 1;
    fork
      for (int i = 0; i < 8; i++)
        send_w({64'h1111_1111_1111_1111 + 64'(i), 8'hFF, (i == 7)});
      begin
        repeat (2) @(posedge clk);
        #1 m_if.wready = 0;
        repeat (3) @(posedge clk);
        #1 m_if.wready = 1;
      end
    join
    idle(4);
    test_w = 0;
    chk("w_stall_cycles", w_low, 3);
    chk("w_beats_out", w_dn, 8);
    chk("w_drain", w_q.size(), 0);

    // continuous AW stream: one address per cycle, one-cycle offset
    test_aw = 1;
    for (int i = 0; i < 8; i++)
      send_aw({64'h0000_0001_0000_0000 + 64'(i * 64), 8'(i), 8'(15 - i), 3'(i), 2'(i),
               1'(i), 4'(i), 3'(i), 4'(i)});
    idle(3);
    test_aw = 0;
    chk("aw_offset", aw_dn_first - aw_up_first, 1);
    chk("aw_spacing", aw_dn_last - aw_dn_first, 7);
    chk("aw_count", aw_dn, 8);
    chk("aw_ready_low", aw_low, 0);

    // B responses with all resp codes
    send_b({8'h11, 2'b00});
    send_b({8'h22, 2'b01});
    send_b({8'h33, 2'b10});
    send_b({8'h44, 2'b11});
    idle(3);
    chk("b_drain", b_q.size(), 0);

    // R burst, SLVERR, rready toggling
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_r({64'hA5A5_0000_0000_0000 + 64'(i), 8'h03, 2'b10, (i == 3)});
        idle(6);
        r_done = 1;
      end
      begin
        @(negedge clk); chk("r_lat_first", int'(s_if.rvalid), 1 - R_LAT);
        @(negedge clk); chk("r_lat_next",  int'(s_if.rvalid), 1);
      end
      while (!r_done) begin
        @(posedge clk);
        #1 s_if.rready = ~s_if.rready;
      end
    join
    s_if.rready = 1;
    idle(3);
    chk("r_drain", r_q.size(), 0);

    // async reset with two beats buffered
    m_if.awready = 0;
    send_aw({64'hDEAD_BEEF_0000_0040, 8'hC1, 8'd0, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h1});
    send_aw({64'hDEAD_BEEF_0000_0080, 8'hC2, 8'd1, 3'd3, 2'b10, 1'b1, 4'hF, 3'h7, 4'hF});
    chk("aw_full_ready", int'(s_if.awready), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(m_if.awvalid), 0);
    chk("async_rst_ready", int'(s_if.awready), 0);
    aw_q.delete();
    m_if.awready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst2", int'({s_if.awready, s_if.wready, s_if.arready}), 7);
    chk("valids_after_rst2", int'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 0);

    // random valid/ready stress on every channel
    fork
      begin
        fork
          for (int i = 0; i < STRESS_N; i++) begin
            idle($urandom_range(0, 2)); r_aw = rnd128(); send_aw(r_aw[AW_PW-1:0]);
          end
          for (int i = 0; i < STRESS_N; i++) begin
            idle($urandom_range(0, 2)); r_w = rnd128(); send_w(r_w[W_PW-1:0]);
          end
          for (int i = 0; i < STRESS_N; i++) begin
            idle($urandom_range(0, 2)); r_ar = rnd128(); send_ar(r_ar[AW_PW-1:0]);
          end
          for (int i = 0; i < STRESS_N; i++) begin
            idle($urandom_range(0, 2)); r_b = rnd128(); send_b(r_b[B_PW-1:0]);
          end
          for (int i = 0; i < STRESS_N; i++) begin
            idle($urandom_range(0, 2)); r_r = rnd128(); send_r(r_r[R_PW-1:0]);
          end
        join
        stress_done = 1;
      end
      while (!stress_done) begin
        @(posedge clk);
        #1;
        m_if.awready = 1'($urandom_range(0, 1));
        m_if.wready  = 1'($urandom_range(0, 1));
        m_if.arready = 1'($urandom_range(0, 1));
        s_if.bready  = 1'($urandom_range(0, 1));
        s_if.rready  = 1'($urandom_range(0, 1));
      end
    join
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1; s_if.bready = 1; s_if.rready = 1;
    idle(10);
    chk("stress_aw_left", aw_q.size(), 0);
    chk("stress_w_left",  w_q.size(), 0);
    chk("stress_ar_left", ar_q.size(), 0);
    chk("stress_b_left",  b_q.size(), 0);
    chk("stress_r_left",  r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
